// File: rtl/ctrl_word_queue.sv
// Control-word FIFO feeding the decoder's x0..x6 inputs.
// Valid/ready on both sides, synchronous flush, sticky drop flag.
module ctrl_word_queue #(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [6:0]    in_word,
  output logic          in_ready,
  input  logic          flush,
  input  logic          out_ready,
  output logic          out_valid,
  output logic          x0,
  output logic          x1,
  output logic          x2,
  output logic          x3,
  output logic          x4,
  output logic          x5,
  output logic          x6,
  output logic [CW-1:0] count,
  output logic          drop_err
);

  localparam int AW = $clog2(DEPTH);

  logic [6:0]    mem_q [DEPTH];
  logic [6:0]    mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          drop_err_q, drop_err_d;
  logic          push, pop;
  logic [6:0]    head;

  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  // Idle word is forced to zero so the decoder never sees stale data
  assign head = out_valid ? mem_q[rd_ptr_q] : 7'h00;
  assign {x6, x5, x4, x3, x2, x1, x0} = head;
  assign count    = count_q;
  assign drop_err = drop_err_q;

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    drop_err_d = drop_err_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      if (count_q != '0 || in_valid)
        drop_err_d = 1'b1;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = in_word;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop)
        rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)
        count_d = count_q + CW'(1);
      else if (pop && !push)
        count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      drop_err_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      drop_err_q <= drop_err_d;
    end
  end

endmodule

// File: tb/tb_ctrl_word_queue.sv
// Directed bench for ctrl_word_queue: vector table plus
// hand-written streaming, stall, flush and reset sequences.
module tb_ctrl_word_queue;

  logic       clk, rst;
  logic       in_valid, in_ready, flush, out_ready, out_valid;
  logic [6:0] in_word;
  logic       x0, x1, x2, x3, x4, x5, x6;
  logic [2:0] count;
  logic       drop_err;
  logic [6:0] xw;

  int n_checks = 0;
  int n_fail   = 0;

  ctrl_word_queue #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_word(in_word), .in_ready(in_ready),
    .flush(flush), .out_ready(out_ready), .out_valid(out_valid),
    .x0(x0), .x1(x1), .x2(x2), .x3(x3), .x4(x4), .x5(x5), .x6(x6),
    .count(count), .drop_err(drop_err)
  );

  assign xw = {x6, x5, x4, x3, x2, x1, x0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    logic       iv;
    logic [6:0] w;
    logic       fl;
    logic       ordy;
    logic       e_ov;
    logic [6:0] e_x;
    logic [2:0] e_cnt;
    logic       e_ir;
    logic       e_de;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(string nm, logic iv, logic [6:0] w,
                              logic fl, logic ordy, logic e_ov,
                              logic [6:0] e_x, logic [2:0] e_cnt,
                              logic e_ir, logic e_de);
    vec_t v;
    v.nm = nm; v.iv = iv; v.w = w; v.fl = fl; v.ordy = ordy;
    v.e_ov = e_ov; v.e_x = e_x; v.e_cnt = e_cnt;
    v.e_ir = e_ir; v.e_de = e_de;
    return v;
  endfunction

  task automatic cmp(string nm, int act, int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk(string nm, logic ov, logic [6:0] x,
                     logic [2:0] c, logic ir, logic de);
    cmp({nm, ".out_valid"}, int'(out_valid), int'(ov));
    cmp({nm, ".x"}, int'(xw), int'(x));
    cmp({nm, ".count"}, int'(count), int'(c));
    cmp({nm, ".in_ready"}, int'(in_ready), int'(ir));
    cmp({nm, ".drop_err"}, int'(drop_err), int'(de));
  endtask

  task automatic drive(logic iv, logic [6:0] w, logic fl, logic ordy);
    in_valid  = iv;
    in_word   = w;
    flush     = fl;
    out_ready = ordy;
  endtask

  task automatic step(logic iv, logic [6:0] w, logic fl, logic ordy);
    drive(iv, w, fl, ordy);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    drive(1'b0, 7'h00, 1'b0, 1'b0);
    #1 rst = 1'b1;
    #1 chk("reset_init", 1'b0, 7'h00, 3'd0, 1'b1, 1'b0);
    @(negedge clk) rst = 1'b0;

    // name, iv, word, flush, out_ready | ov, x, count, in_ready, drop
    vq.push_back(mk("push55",   1, 7'h55, 0, 0, 1, 7'h55, 3'd1, 1, 0));
    vq.push_back(mk("pop55",    0, 7'h00, 0, 1, 0, 7'h00, 3'd0, 1, 0));
    vq.push_back(mk("fill1",    1, 7'h01, 0, 0, 1, 7'h01, 3'd1, 1, 0));
    vq.push_back(mk("fill2",    1, 7'h02, 0, 0, 1, 7'h01, 3'd2, 1, 0));
    vq.push_back(mk("fill3",    1, 7'h03, 0, 0, 1, 7'h01, 3'd3, 1, 0));
    vq.push_back(mk("fill4",    1, 7'h04, 0, 0, 1, 7'h01, 3'd4, 0, 0));
    vq.push_back(mk("full_rej", 1, 7'h05, 0, 0, 1, 7'h01, 3'd4, 0, 0));
    vq.push_back(mk("drain1",   1, 7'h05, 0, 1, 1, 7'h02, 3'd3, 1, 0));
    vq.push_back(mk("drain2",   1, 7'h05, 0, 1, 1, 7'h03, 3'd3, 1, 0));
    vq.push_back(mk("drain3",   0, 7'h00, 0, 1, 1, 7'h04, 3'd2, 1, 0));
    vq.push_back(mk("drain4",   0, 7'h00, 0, 1, 1, 7'h05, 3'd1, 1, 0));
    vq.push_back(mk("drain5",   0, 7'h00, 0, 1, 0, 7'h00, 3'd0, 1, 0));
    vq.push_back(mk("empty_pp", 1, 7'h66, 0, 1, 1, 7'h66, 3'd1, 1, 0));
    vq.push_back(mk("pop66",    0, 7'h00, 0, 1, 0, 7'h00, 3'd0, 1, 0));
    vq.push_back(mk("fl_empty", 0, 7'h00, 1, 1, 0, 7'h00, 3'd0, 1, 0));

    foreach (vq[i]) begin
      step(vq[i].iv, vq[i].w, vq[i].fl, vq[i].ordy);
      chk(vq[i].nm, vq[i].e_ov, vq[i].e_x, vq[i].e_cnt,
          vq[i].e_ir, vq[i].e_de);
    end

    // Streaming: one push and one pop per cycle across pointer wraps
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 7'(k), 1'b0, 1'b1);
      chk($sformatf("stream%0d", k), 1'b1, 7'(k), 3'd1, 1'b1, 1'b0);
    end
    step(1'b0, 7'h00, 1'b0, 1'b1);
    chk("stream_end", 1'b0, 7'h00, 3'd0, 1'b1, 1'b0);

    // Stall: head must hold while the consumer is not ready
    step(1'b1, 7'h2A, 1'b0, 1'b0);
    chk("stall_head", 1'b1, 7'h2A, 3'd1, 1'b1, 1'b0);
    for (int k = 0; k < 10; k++) begin
      step(k == 0, 7'h11, 1'b0, 1'b0);
      chk($sformatf("stall%0d", k), 1'b1, 7'h2A, 3'd2, 1'b1, 1'b0);
    end
    step(1'b0, 7'h00, 1'b0, 1'b1);
    chk("stall_pop1", 1'b1, 7'h11, 3'd1, 1'b1, 1'b0);
    step(1'b0, 7'h00, 1'b0, 1'b1);
    chk("stall_pop2", 1'b0, 7'h00, 3'd0, 1'b1, 1'b0);

    // Flush with three words queued and a simultaneous push of 7F
    step(1'b1, 7'h10, 1'b0, 1'b0);
    step(1'b1, 7'h20, 1'b0, 1'b0);
    step(1'b1, 7'h30, 1'b0, 1'b0);
    chk("pre_flush", 1'b1, 7'h10, 3'd3, 1'b1, 1'b0);
    step(1'b1, 7'h7F, 1'b1, 1'b1);
    chk("flush", 1'b0, 7'h00, 3'd0, 1'b1, 1'b1);
    step(1'b1, 7'h12, 1'b0, 1'b0);
    chk("post_fl_push", 1'b1, 7'h12, 3'd1, 1'b1, 1'b1);
    step(1'b1, 7'h13, 1'b0, 1'b1);
    chk("post_fl_pp", 1'b1, 7'h13, 3'd1, 1'b1, 1'b1);

    // Asynchronous reset mid-cycle with a word queued
    drive(1'b0, 7'h00, 1'b0, 1'b0);
    #3 rst = 1'b1;
    #1 chk("async_rst", 1'b0, 7'h00, 3'd0, 1'b1, 1'b0);
    @(negedge clk) rst = 1'b0;
    step(1'b1, 7'h55, 1'b0, 1'b0);
    chk("rst_push55", 1'b1, 7'h55, 3'd1, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
